// File: rtl/pipe_pkg.sv
// ------------------------------------------------------------------
// pipe_pkg: field widths, slice state encoding and EX/MEM pack helpers.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int WB_W         = 4;
  localparam int MEM_W        = 2;
  localparam int WORD_W       = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int EXMEM_CTRL_W = WB_W + MEM_W;
  localparam int EXMEM_DATA_W = 1 + 2 * WORD_W + REG_ADDR_W;

  localparam int SLICE_ST_W = 2;
  localparam logic [SLICE_ST_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [SLICE_ST_W-1:0] ST_ONE   = 2'd1;
  localparam logic [SLICE_ST_W-1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic                  zero;
    logic [WORD_W-1:0]     alu;
    logic [WORD_W-1:0]     write_d;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_data_t;

  function automatic logic [EXMEM_DATA_W-1:0] pack_exmem(input exmem_data_t f);
    return {f.zero, f.alu, f.write_d, f.rd};
  endfunction

  function automatic exmem_data_t unpack_exmem(input logic [EXMEM_DATA_W-1:0] v);
    exmem_data_t f;
    f.zero    = v[EXMEM_DATA_W-1];
    f.alu     = v[EXMEM_DATA_W-2 -: WORD_W];
    f.write_d = v[REG_ADDR_W+WORD_W-1 -: WORD_W];
    f.rd      = v[REG_ADDR_W-1:0];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_skid_slice.sv
// ------------------------------------------------------------------
// pipe_skid_slice: one elastic slice (main + optional skid register).
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_skid_slice
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = EXMEM_CTRL_W,
  parameter int DATA_W    = EXMEM_DATA_W,
  parameter bit REG_READY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        count
);

  logic [SLICE_ST_W-1:0] state_q, state_d;
  logic [CTRL_W-1:0]     main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]     main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                  rdy_q, rdy_d;
  logic                  accept, emit;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      rdy_q       <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Control regs are kept zero whenever their entry is empty, so out_ctrl needs no gating.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    skid_ctrl_d = skid_ctrl_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      ST_ONE: begin
        if (emit && accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (emit) begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end else if (accept && REG_READY) begin
          state_d     = ST_FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_d     = ST_ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
      end
    endcase
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end
    // rdy_q also holds in_ready low through reset and releases it one edge later.
    rdy_d = REG_READY ? (state_d != ST_FULL) : 1'b1;
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
    in_ready  = REG_READY ? rdy_q : (rdy_q & ((state_q == ST_EMPTY) | out_ready));
    count     = (state_q == ST_FULL) ? 2'd2 : ((state_q == ST_ONE) ? 2'd1 : 2'd0);
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
// ------------------------------------------------------------------
// pipe_stage_elastic: STAGES cascaded elastic slices with flush and occupancy.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = EXMEM_CTRL_W,
  parameter int DATA_W    = EXMEM_DATA_W,
  parameter int STAGES    = 1,
  parameter bit REG_READY = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CTRL_W-1:0]                in_ctrl,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CTRL_W-1:0]                out_ctrl,
  output logic [DATA_W-1:0]                out_data,
  input  logic                             flush,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int OCC_W   = $clog2(2 * STAGES + 1);
  localparam int MAX_OCC = REG_READY ? 2 * STAGES : STAGES;

  logic              chain_valid [STAGES+1];
  logic              chain_ready [STAGES+1];
  logic [CTRL_W-1:0] chain_ctrl  [STAGES+1];
  logic [DATA_W-1:0] chain_data  [STAGES+1];
  logic [1:0]        slice_count [STAGES];
  logic [OCC_W-1:0]  occ_sum;

  assign chain_valid[0]      = in_valid;
  assign chain_ctrl[0]       = in_ctrl;
  assign chain_data[0]       = in_data;
  assign in_ready            = chain_ready[0];
  assign chain_ready[STAGES] = out_ready;
  assign out_valid           = chain_valid[STAGES];
  assign out_ctrl            = chain_ctrl[STAGES];
  assign out_data            = chain_data[STAGES];

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_slice
      pipe_skid_slice #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .REG_READY (REG_READY)
      ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (chain_valid[i]),
        .in_ready  (chain_ready[i]),
        .in_ctrl   (chain_ctrl[i]),
        .in_data   (chain_data[i]),
        .out_valid (chain_valid[i+1]),
        .out_ready (chain_ready[i+1]),
        .out_ctrl  (chain_ctrl[i+1]),
        .out_data  (chain_data[i+1]),
        .flush     (flush),
        .count     (slice_count[i])
      );
    end
  endgenerate

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_sum = occ_sum + OCC_W'(slice_count[i]);
    end
  end

  assign occupancy = occ_sum;

  a_occ_max: assert property (@(posedge clk) disable iff (!rst) occupancy <= OCC_W'(MAX_OCC));

endmodule

`default_nettype wire
